serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Multi-cycle, bit-serial subtractor: `minuend - subtrahend - bi`, one bit per clock, LSB first, through a single full-subtractor cell with a registered borrow. It is the inverse arithmetic path of the ripple-carry adder in the same arithmetic library. It serves datapaths that trade latency for area. A start/busy/done handshake frames each operation, and results are held until the next operation completes.

## Interface
- `WIDTH`, default 4: operand and result width in bits; legal range 2–32.

- `clk`  input  1: rising-edge clock.
- `reset`  input  1: asynchronous, active-high reset.
- `start`  input  1: request a subtraction; sampled only in IDLE or DONE.
- `minuend`  input  WIDTH: operand A; captured on the accepting edge.
- `subtrahend`  input  WIDTH: operand B; captured on the accepting edge.
- `bi`  input  1: borrow-in; captured on the accepting edge.
- `busy`  output  1: high while in RUN.
- `done`  output  1: one-cycle pulse; `difference` and `borrow` are newly valid.
- `difference`  output  WIDTH: result, A - B - bi, modulo 2^WIDTH.
- `borrow`  output  1: borrow-out from the MSB.

## Operation
- States are IDLE, RUN and DONE. All outputs reset to 0 and the state resets to IDLE.
- **IDLE**
  - `start` = 1 latches `minuend`, `subtrahend` and `bi` into shift registers `a_sr`, `b_sr` and `br`.
  - Clears bit counter `cnt` (width `$clog2(WIDTH)+1`) to 0.
  - Moves to RUN.
- **RUN**, each edge:
  - `d = a_sr[0] ^ b_sr[0] ^ br`.
  - `br <= (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br)`.
  - `a_sr` and `b_sr` shift right by one.
  - `d` is shifted into the MSB of internal `d_sr`, so the LSB enters first.
  - `cnt` increments.
- **RUN exit**: on the edge where `cnt == WIDTH-1`:
  - `difference` is loaded with the fully shifted `d_sr`.
  - `borrow` is loaded with the final borrow.
  - State moves to DONE.
- **DONE** lasts one cycle, with `done` = 1.
  - If `start` = 1, a new operation is accepted exactly as from IDLE, and the state goes to RUN.
  - Otherwise the state goes to IDLE.
- `start` is ignored in RUN. No queuing, no error flag.
- `difference` and `borrow` change only on the completing edge and hold their values through IDLE indefinitely.
- Asserting `reset` mid-RUN aborts the operation:
  - Outputs return to 0 and `done` is not pulsed.
  - Partial results are discarded.
- Operand inputs may change freely after the accepting edge.

## Timing
- Accepting edge E0 (start sampled in IDLE or DONE): `busy` = 1 from E0 until the completing edge.
- Completing edge is E0+WIDTH. `done`, `difference` and `borrow` are valid in the cycle following it.
- Latency is WIDTH cycles from acceptance to `done`.
- Back-to-back throughput is one result per WIDTH+1 cycles, using start-in-DONE.
- No combinational path from inputs to outputs; all outputs are registered.
- `reset` takes effect immediately (asynchronous assertion). The design assumes release is synchronised to `clk` externally.

## Configuration
- Macro: `SERIAL_SUB_SATURATE_EN`.
- **Defined**: on completion, if the final borrow = 1, `difference` is forced to 0 (unsigned floor). `borrow` still reports 1.
- **Undefined**: `difference` is the modulo-2^WIDTH (two's-complement wrap) result.
- Handshake and latency are identical in both builds.

## Test plan
- WIDTH=4, A=9, B=3, bi=0, start pulsed:
  - `busy` is high for 4 cycles.
  - `done` pulses once with `difference` = 6, `borrow` = 0.
- A=3, B=9, bi=0:
  - Without the macro: `difference` = 0xA, `borrow` = 1.
  - With `SERIAL_SUB_SATURATE_EN`: `difference` = 0, `borrow` = 1.
- A=0, B=0, bi=1: `difference` = 0xF, `borrow` = 1. With the macro: `difference` = 0, `borrow` = 1.
- Start 7-2; in RUN cycle 2 present `start` = 1 with A=15, B=1:
  - The second request is ignored.
  - `done` reports 5 / 0.
  - No second `done` follows.
- Start 12-5, then hold `start` = 1 during the DONE cycle with A=4, B=4, bi=0:
  - First `done` reports 7 / 0.
  - Second `done` follows 5 cycles later with 0 / 0.
- Start 8-1, assert `reset` at RUN cycle 2:
  - All outputs go to 0 immediately and `done` never pulses.
  - After release, a new 5-5 operation completes normally with 0 / 0.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - bi through one full-subtractor cell; WIDTH cycles accept-to-done, start ignored while busy.
// Build option SERIAL_SUB_SATURATE_EN floors a negative result to 0 (borrow still reported).
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  input  logic             bi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] difference,
  output logic             borrow
);

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             br;
  logic [CW-1:0]    cnt;
  logic [WIDTH-2:0] d_sr;

  logic             d;
  logic             br_nxt;
  logic [WIDTH-1:0] d_full;

  assign d      = a_sr[0] ^ b_sr[0] ^ br;
  assign br_nxt = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
  // d_sr only needs WIDTH-1 bits: the last difference bit goes straight to the output.
  assign d_full = {d, d_sr};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      d_sr       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      difference <= '0;
      borrow     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= minuend;
            b_sr  <= subtrahend;
            br    <= bi;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          br   <= br_nxt;
          d_sr <= d_full[WIDTH-1:1];
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
`ifdef SERIAL_SUB_SATURATE_EN
            difference <= br_nxt ? '0 : d_full;
`else
            difference <= d_full;
`endif
            borrow <= br_nxt;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor (WIDTH=4): vector table, handshake corner cases, random ops vs arithmetic model.
module tb_serial_subtractor;
  localparam int W = 4;
`ifdef SERIAL_SUB_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] minuend;
  logic [W-1:0] subtrahend;
  logic         bi;
  logic         busy;
  logic         done;
  logic [W-1:0] difference;
  logic         borrow;

  int errors = 0;
  int checks = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .minuend(minuend),
    .subtrahend(subtrahend), .bi(bi), .busy(busy), .done(done),
    .difference(difference), .borrow(borrow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bi;
    logic [W-1:0] d;
    logic         bo;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: plain integer subtraction, negative result means borrow.
  function automatic void model(input int a, input int b, input int bin,
                                output logic [W-1:0] d, output logic bo);
    int r;
    r  = a - b - bin;
    bo = (r < 0);
    d  = W'(r);
    if (SAT && bo) d = '0;
  endfunction

  // Called at a negedge; counts negedges until done is seen (timeout -> lat = -1).
  task automatic wait_done(output int lat, output int busy_n,
                           output logic [W-1:0] d, output logic bo);
    lat = -1; busy_n = 0; d = 'x; bo = 1'bx;
    for (int k = 1; k <= 3 * W; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        lat = k; d = difference; bo = borrow;
        break;
      end
    end
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    start = 1'b1; minuend = a; subtrahend = b; bi = bin;
    @(posedge clk);
    #1;
    start = 1'b0;
    minuend = W'($urandom); subtrahend = W'($urandom); bi = 1'($urandom);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        output int lat, output int busy_n,
                        output logic [W-1:0] d, output logic bo);
    launch(a, b, bin);
    wait_done(lat, busy_n, d, bo);
  endtask

  task automatic count_dones(input int n, output int cnt_o);
    cnt_o = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (done) cnt_o++;
    end
  endtask

  initial begin
    int lat, busy_n, nd;
    logic [W-1:0] gd, ed;
    logic gb, eb;
    logic [W-1:0] ra, rb;
    logic rbi;

    tbl[0] = '{a: 4'd9,  b: 4'd3,  bi: 1'b0, d: 4'd6,  bo: 1'b0};
    tbl[1] = '{a: 4'd3,  b: 4'd9,  bi: 1'b0, d: 4'hA,  bo: 1'b1};
    tbl[2] = '{a: 4'd0,  b: 4'd0,  bi: 1'b1, d: 4'hF,  bo: 1'b1};
    tbl[3] = '{a: 4'd15, b: 4'd15, bi: 1'b0, d: 4'd0,  bo: 1'b0};
    tbl[4] = '{a: 4'd15, b: 4'd0,  bi: 1'b1, d: 4'd14, bo: 1'b0};
    tbl[5] = '{a: 4'd7,  b: 4'd7,  bi: 1'b1, d: 4'hF,  bo: 1'b1};
    tbl[6] = '{a: 4'd0,  b: 4'd15, bi: 1'b0, d: 4'd1,  bo: 1'b1};

    reset = 1'b1; start = 1'b0; minuend = '0; subtrahend = '0; bi = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_diff", 32'(difference), 0);
    chk("reset_borrow", 32'(borrow), 0);
    reset = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].bi, lat, busy_n, gd, gb);
      ed = (SAT && tbl[i].bo) ? '0 : tbl[i].d;
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(W + 1));
      chk($sformatf("vec%0d_busy_cycles", i), 32'(busy_n), 32'(W));
      chk($sformatf("vec%0d_diff", i), 32'(gd), 32'(ed));
      chk($sformatf("vec%0d_borrow", i), 32'(gb), 32'(tbl[i].bo));
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse_ends", i), 32'(done), 0);
    end

    // Result held through a long IDLE stretch (last vector: 0-15 -> 1/1).
    repeat (6) @(negedge clk);
    chk("hold_diff", 32'(difference), SAT ? 0 : 1);
    chk("hold_borrow", 32'(borrow), 1);

    // Back-to-back: 12-5, then start held in the DONE cycle with 4-4.
    launch(4'd12, 4'd5, 1'b0);
    wait_done(lat, busy_n, gd, gb);
    chk("b2b_first_diff", 32'(gd), 7);
    chk("b2b_first_borrow", 32'(gb), 0);
    launch(4'd4, 4'd4, 1'b0);
    wait_done(lat, busy_n, gd, gb);
    chk("b2b_second_gap", 32'(lat), 5);
    chk("b2b_second_diff", 32'(gd), 0);
    chk("b2b_second_borrow", 32'(gb), 0);
    @(negedge clk);

    // start during RUN is ignored: 7-2 runs, 15-1 request dropped.
    launch(4'd7, 4'd2, 1'b0);
    @(negedge clk);
    start = 1'b1; minuend = 4'd15; subtrahend = 4'd1; bi = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, busy_n, gd, gb);
    chk("ignore_diff", 32'(gd), 5);
    chk("ignore_borrow", 32'(gb), 0);
    count_dones(3 * W, nd);
    chk("ignore_no_second_done", 32'(nd), 0);
    chk("ignore_idle_busy", 32'(busy), 0);

    // Reset mid-RUN: 8-1 aborted, outputs drop immediately.
    launch(4'd8, 4'd1, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_diff", 32'(difference), 0);
    chk("abort_borrow", 32'(borrow), 0);
    @(negedge clk);
    reset = 1'b0;
    count_dones(3 * W, nd);
    chk("abort_no_done", 32'(nd), 0);
    run_op(4'd5, 4'd5, 1'b0, lat, busy_n, gd, gb);
    chk("after_abort_latency", 32'(lat), 32'(W + 1));
    chk("after_abort_diff", 32'(gd), 0);
    chk("after_abort_borrow", 32'(gb), 0);
    @(negedge clk);

    // Random operations against the arithmetic model.
    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom); rb = W'($urandom); rbi = 1'($urandom);
      model(int'(ra), int'(rb), int'(rbi), ed, eb);
      run_op(ra, rb, rbi, lat, busy_n, gd, gb);
      chk($sformatf("rand%0d_latency", n), 32'(lat), 32'(W + 1));
      chk($sformatf("rand%0d_diff", n), 32'(gd), 32'(ed));
      chk($sformatf("rand%0d_borrow", n), 32'(gb), 32'(eb));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
